clk_rst_ctrl: RTL and testbench



---
 rtl/clk_rst_pkg.sv | 25 ++
 rtl/clk_rst_ctrl_sync_bit.sv | 24 ++
 rtl/clk_rst_ctrl.sv | 135 +++++++++++++
 tb/tb_clk_rst_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_rst_pkg.sv
// Shared state encoding, default divider/hold constants and counter-width helpers
// for the clk_rst_ctrl reset and clock-enable block.
package clk_rst_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int CPU_DIV_DEF     = 8;
    localparam int PIX_DIV_DEF     = 4;
    localparam int HOLD_CYCLES_DEF = 1024;

    // Width of a counter that walks 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Hold counter carries one spare bit so it can saturate without wrapping.
    function automatic int hold_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/clk_rst_ctrl_sync_bit.sv
// Multi-stage flip-flop synchronizer for a single asynchronous level,
// cleared asynchronously to 0 by an active-high clear.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/clk_rst_ctrl.sv
// Core reset sequencer and pixel/CPU clock-enable divider behind the PLL.
// Optional macro CLK_RST_PAUSE_EN lets `pause` freeze the CPU enables while video runs on.
module clk_rst_ctrl
    import clk_rst_pkg::*;
#(
    parameter int CPU_DIV     = CPU_DIV_DEF,
    parameter int PIX_DIV     = PIX_DIV_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic pll_locked,
    input  logic pause,
    output logic reset_out,
    output logic ce_pix,
    output logic ce_cpu,
    output logic ce_cpu_n,
    output logic ready
);

    localparam int DIV_W  = cnt_width(CPU_DIV);
    localparam int HOLD_W = hold_width(HOLD_CYCLES);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CPU_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CPU_DIV / 2 - 1);
    localparam logic [DIV_W-1:0]  PIX_MASK  = DIV_W'(PIX_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;

    state_t             state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [DIV_W-1:0]   div_cnt;
    logic [DIV_W-1:0]   div_nxt;
    logic               lock_s;
    logic               cpu_hold_nxt;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (clk_sys),
        .clr (reset),
        .d   (pll_locked),
        .q   (lock_s)
    );

    // Power-of-two CPU_DIV makes the natural wrap of div_cnt the modulo.
    assign div_nxt = div_cnt + 1'b1;

`ifdef CLK_RST_PAUSE_EN
    logic cpu_hold;
    logic run_stay;

    assign run_stay = (state == RUN) && lock_s;

    // A pause holds the CPU enables off until the divider next wraps to 0,
    // so the first enable after release is always the ce_cpu_n half.
    assign cpu_hold_nxt = pause | (cpu_hold & (div_nxt != '0));

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cpu_hold <= 1'b0;
        end else begin
            cpu_hold <= run_stay ? cpu_hold_nxt : 1'b0;
        end
    end
`else
    logic unused_pause;

    assign unused_pause = pause;
    assign cpu_hold_nxt = 1'b0;
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= WAIT_LOCK;
            hold_cnt  <= '0;
            div_cnt   <= '0;
            reset_out <= 1'b1;
            ce_pix    <= 1'b0;
            ce_cpu    <= 1'b0;
            ce_cpu_n  <= 1'b0;
        end else begin
            ce_pix   <= 1'b0;
            ce_cpu   <= 1'b0;
            ce_cpu_n <= 1'b0;
            case (state)
                WAIT_LOCK: begin
                    reset_out <= 1'b1;
                    hold_cnt  <= '0;
                    div_cnt   <= '0;
                    if (lock_s) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (!lock_s) begin
                        state    <= WAIT_LOCK;
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state     <= RUN;
                        reset_out <= 1'b0;
                        div_cnt   <= '0;
                    end else if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state     <= WAIT_LOCK;
                        reset_out <= 1'b1;
                        hold_cnt  <= '0;
                        div_cnt   <= '0;
                    end else begin
                        // Enables decode the value div_cnt is about to take, so each
                        // pulse lines up with the cycle in which div_cnt holds it.
                        div_cnt  <= div_nxt;
                        ce_pix   <= (div_nxt & PIX_MASK) == PIX_MASK;
                        ce_cpu   <= (div_nxt == DIV_LAST) && !cpu_hold_nxt;
                        ce_cpu_n <= (div_nxt == DIV_HALF) && !cpu_hold_nxt;
                    end
                end
                default: begin
                    state     <= WAIT_LOCK;
                    reset_out <= 1'b1;
                    hold_cnt  <= '0;
                    div_cnt   <= '0;
                end
            endcase
        end
    end

    assign ready = ~reset_out;

endmodule

// File: tb/tb_clk_rst_ctrl.sv
// Bench for clk_rst_ctrl: table-driven release/enable/lock-loss vectors, hand sequences
// for hold glitch, pause and async reset, then randomized traffic against a cycle-count model.
module tb_clk_rst_ctrl;

    localparam int CPU  = 8;
    localparam int PIX  = 4;
    localparam int HOLD = 16;
    localparam int SYNC = 2;

`ifdef CLK_RST_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic clk_sys = 1'b0;
    logic reset;
    logic pll_locked;
    logic pause;
    logic reset_out;
    logic ce_pix;
    logic ce_cpu;
    logic ce_cpu_n;
    logic ready;

    int checks   = 0;
    int failures = 0;

    // Reference model: lock samples since reset, length of the current unbroken
    // run of synchronized-high lock, and whether a pause is pending this CPU period.
    int samp[$];
    int ones;
    bit blocked;
    bit m_rst, m_pix, m_cpu, m_cpun;

    typedef struct {
        string name;
        bit    lock;
        int    n;
        bit    rst;
        bit    pix;
        bit    cpu;
        bit    cpun;
    } vec_t;

    vec_t tbl[11];

    clk_rst_ctrl #(
        .CPU_DIV     (CPU),
        .PIX_DIV     (PIX),
        .HOLD_CYCLES (HOLD),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .pll_locked (pll_locked),
        .pause      (pause),
        .reset_out  (reset_out),
        .ce_pix     (ce_pix),
        .ce_cpu     (ce_cpu),
        .ce_cpu_n   (ce_cpu_n),
        .ready      (ready)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk_v(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: {rst,ready,pix,cpu,cpun} got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] outs();
        return {reset_out, ready, ce_pix, ce_cpu, ce_cpu_n};
    endfunction

    task automatic model_clear();
        samp.delete();
        ones    = 0;
        blocked = 1'b0;
        m_rst   = 1'b1;
        m_pix   = 1'b0;
        m_cpu   = 1'b0;
        m_cpun  = 1'b0;
    endtask

    // Lock seen by the sequencer at edge n is the pin value sampled SYNC edges earlier;
    // reset releases once HOLD+1 consecutive high samples have been seen, and the
    // RUN phase p counts edges from that release.
    task automatic model_update(input bit lock, input bit pse);
        int n;
        int l;
        int p;
        samp.push_back(int'(lock));
        n = samp.size();
        l = (n > SYNC) ? samp[n-1-SYNC] : 0;
        ones  = (l != 0) ? ones + 1 : 0;
        m_rst = (ones < HOLD + 1);
        p     = ones - (HOLD + 1);
        if (m_rst) begin
            blocked = 1'b0;
        end else begin
            if (p % CPU == 0) blocked = 1'b0;
            if (p >= 1 && pse) blocked = 1'b1;
        end
        m_pix  = !m_rst && (p % PIX == PIX - 1);
        m_cpu  = !m_rst && (p % CPU == CPU - 1)     && !(PAUSE_EN && blocked);
        m_cpun = !m_rst && (p % CPU == CPU / 2 - 1) && !(PAUSE_EN && blocked);
    endtask

    // Entered and left at a falling edge; inputs are stable across the rising edge.
    task automatic cycle(input bit lock, input bit pse);
        pll_locked = lock;
        pause      = pse;
        @(posedge clk_sys);
        model_update(lock, pse);
        #1;
        chk_v("model", outs(), {m_rst, !m_rst, m_pix, m_cpu, m_cpun});
        @(negedge clk_sys);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        model_clear();
        chk_v("reset_async", outs(), 5'b10000);
        repeat (2) @(posedge clk_sys);
        #1;
        chk_v("reset_state", outs(), 5'b10000);
        @(negedge clk_sys);
        reset = 1'b0;
    endtask

    initial begin
        int n_pix, n_cpu, n_cpun, n_ovl, first;
        bit lk, ps;
        int drop_left;

        tbl[0]  = '{"hold_not_done",   1'b1, 18, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{"release_edge",    1'b1,  1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{"first_pix_cpun",  1'b1,  3, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{"gap_p4",          1'b1,  1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{"first_cpu",       1'b1,  3, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{"wrap_p8",         1'b1,  1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{"lock_drop_e1",    1'b0,  1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{"lock_drop_e2",    1'b0,  1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{"lock_drop_e3",    1'b0,  1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{"relock_hold",     1'b1, 18, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{"relock_release",  1'b1,  1, 1'b0, 1'b0, 1'b0, 1'b0};

        reset      = 1'b1;
        pll_locked = 1'b1;
        pause      = 1'b0;
        apply_reset();

        for (int i = 0; i < 11; i++) begin
            repeat (tbl[i].n) cycle(tbl[i].lock, 1'b0);
            chk_v(tbl[i].name, outs(),
                  {tbl[i].rst, !tbl[i].rst, tbl[i].pix, tbl[i].cpu, tbl[i].cpun});
        end

        // Steady RUN window: pulse counts and mutual exclusion.
        n_pix = 0; n_cpu = 0; n_cpun = 0; n_ovl = 0;
        for (int i = 0; i < 64; i++) begin
            cycle(1'b1, 1'b0);
            n_pix  += int'(ce_pix);
            n_cpu  += int'(ce_cpu);
            n_cpun += int'(ce_cpu_n);
            if (ce_cpu && ce_cpu_n) n_ovl++;
            if (ce_cpu && !ce_pix)  n_ovl++;
        end
        chk_i("pattern_pix",  n_pix,  16);
        chk_i("pattern_cpu",  n_cpu,  8);
        chk_i("pattern_cpun", n_cpun, 8);
        chk_i("pattern_overlap", n_ovl, 0);

        // Pause for 20 cycles, then find the first CPU enable after release.
        n_pix = 0; n_cpu = 0; n_cpun = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1);
            n_pix  += int'(ce_pix);
            n_cpu  += int'(ce_cpu);
            n_cpun += int'(ce_cpu_n);
        end
        chk_i("pause_pix", n_pix, 5);
`ifdef CLK_RST_PAUSE_EN
        chk_i("pause_cpu_total", n_cpu + n_cpun, 0);
        first = 0;
        for (int i = 0; i < 16 && first == 0; i++) begin
            cycle(1'b1, 1'b0);
            if (ce_cpu_n) first = 2;
            else if (ce_cpu) first = 1;
        end
        chk_i("pause_first_is_cpun", first, 2);
`else
        chk_i("pause_ignored_cpu_total", n_cpu + n_cpun, 5);
`endif

        // Asynchronous reset mid-cycle while running.
        repeat (5) cycle(1'b1, 1'b0);
        chk_i("pre_async_run", int'(reset_out), 0);
        #2;
        reset = 1'b1;
        #1;
        chk_v("async_mid_cycle", outs(), 5'b10000);
        model_clear();
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        reset = 1'b0;

        // Lock glitch during HOLD: 11 good samples, 4 low, then steady; release at edge 34.
        apply_reset();
        for (int e = 1; e <= 40; e++) begin
            cycle((e <= 11 || e >= 16), 1'b0);
            chk_i("glitch_hold_rst", int'(reset_out), (e < 34) ? 1 : 0);
        end

        // Randomized lock drops, pause toggles and occasional resets.
        drop_left = 0;
        ps = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (drop_left > 0) begin
                lk = 1'b0;
                drop_left--;
            end else if ($urandom_range(0, 149) == 0) begin
                lk = 1'b0;
                drop_left = $urandom_range(0, 5);
            end else begin
                lk = 1'b1;
            end
            if ($urandom_range(0, 24) == 0) ps = ~ps;
            if ($urandom_range(0, 999) == 0) apply_reset();
            cycle(lk, ps);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
